// File: rtl/fir_out_sink_if.sv
// rtl/fir_out_sink_if.sv - FIR result input and sample output handshake bundle for fir_out_sink
interface fir_out_sink_if #(
  parameter int DIN_W  = 41,
  parameter int DOUT_W = 16
);
  logic [DIN_W-1:0]  fir_dout;
  logic              fir_valid;
  logic [DOUT_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  // Side that feeds FIR results in and consumes samples
  modport master (
    output fir_dout, fir_valid, out_ready,
    input  out_data, out_valid
  );

  // The sink itself
  modport slave (
    input  fir_dout, fir_valid, out_ready,
    output out_data, out_valid
  );
endinterface

// File: rtl/fir_out_sink.sv
// rtl/fir_out_sink.sv - FIR result capture, round/shift/saturate, FIFO to downstream; FIR_SINK_ROUND_EN enables rounding
module fir_out_sink #(
  parameter int DIN_W  = 41,
  parameter int DOUT_W = 16,
  parameter int SHIFT  = 15,
  parameter int DEPTH  = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rstn,
  fir_out_sink_if.slave bus,
  input  logic          clear,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic [7:0]    sat_cnt
);

  logic              fir_valid_q;
  logic              stage_valid_q;
  logic [DOUT_W-1:0] stage_data_q;
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q, count_d;
  logic              overflow_q;
  logic [7:0]        sat_cnt_q;
  logic [DOUT_W-1:0] mem_q [DEPTH];

  logic                    cap;
  logic signed [DIN_W:0]   ext_w;
  logic signed [DIN_W:0]   shr_w;
  logic [DIN_W-DOUT_W+1:0] upper_w;
  logic                    sat_hi, sat_lo;
  logic [DOUT_W-1:0]       res_w;
  logic                    full, pop, wr_en, drop;

  // A new result is the rising edge of the level valid
  assign cap   = bus.fir_valid && !fir_valid_q;
  assign ext_w = {bus.fir_dout[DIN_W-1], bus.fir_dout};

`ifdef FIR_SINK_ROUND_EN
  localparam logic [DIN_W:0] HALF = {{DIN_W{1'b0}}, 1'b1} << (SHIFT-1);
  assign shr_w = (ext_w + $signed(HALF)) >>> SHIFT;
`else
  assign shr_w = ext_w >>> SHIFT;
`endif

  // The shifted value fits DOUT_W bits only when all bits from the output sign bit upward agree
  assign upper_w = shr_w[DIN_W:DOUT_W-1];
  assign sat_hi  = !shr_w[DIN_W] && (|upper_w);
  assign sat_lo  = shr_w[DIN_W] && !(&upper_w);
  assign res_w   = sat_hi ? {1'b0, {(DOUT_W-1){1'b1}}} :
                   sat_lo ? {1'b1, {(DOUT_W-1){1'b0}}} :
                            shr_w[DOUT_W-1:0];

  // FIFO control: a pop in the same cycle frees room for the stage write
  always_comb begin
    full    = (count_q == (AW+1)'(DEPTH));
    pop     = !clear && (count_q != '0) && bus.out_ready;
    wr_en   = !clear && stage_valid_q && (!full || pop);
    drop    = !clear && stage_valid_q && full && !pop;
    count_d = count_q + (AW+1)'(wr_en) - (AW+1)'(pop);
  end

  // Capture edge, stage register, pointers, occupancy and status counters
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fir_valid_q   <= 1'b1;
      stage_valid_q <= 1'b0;
      stage_data_q  <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      overflow_q    <= 1'b0;
      sat_cnt_q     <= '0;
    end else begin
      fir_valid_q <= bus.fir_valid;
      if (clear) begin
        stage_valid_q <= 1'b0;
        wr_ptr_q      <= '0;
        rd_ptr_q      <= '0;
        count_q       <= '0;
        overflow_q    <= 1'b0;
        sat_cnt_q     <= '0;
      end else begin
        stage_valid_q <= cap;
        if (cap) stage_data_q <= res_w;
        if (cap && (sat_hi || sat_lo) && (sat_cnt_q != 8'hFF)) sat_cnt_q <= sat_cnt_q + 8'd1;
        if (drop) overflow_q <= 1'b1;
        if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
        count_q <= count_d;
      end
    end
  end

  // Sample storage; contents are only meaningful below count
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= stage_data_q;
  end

  assign bus.out_valid = (count_q != '0);
  assign bus.out_data  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count         = count_q;
  assign overflow      = overflow_q;
  assign sat_cnt       = sat_cnt_q;

endmodule

// File: tb/tb_fir_out_sink.sv
// tb/tb_fir_out_sink.sv - directed scoreboard bench for fir_out_sink
module tb_fir_out_sink;
  logic       clk = 1'b0;
  logic       rstn;
  logic       clear;
  logic [3:0] count;
  logic       overflow;
  logic [7:0] sat_cnt;

  int tests = 0;
  int fails = 0;
  logic [15:0] sb[$];
  logic [15:0] exp_q;

  fir_out_sink_if #(.DIN_W(41), .DOUT_W(16)) bus ();

  fir_out_sink #(.DIN_W(41), .DOUT_W(16), .SHIFT(15), .DEPTH(8)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .bus      (bus),
    .clear    (clear),
    .count    (count),
    .overflow (overflow),
    .sat_cnt  (sat_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] model(input longint v);
    longint r;
`ifdef FIR_SINK_ROUND_EN
    r = (v + 64'sd16384) >>> 15;
`else
    r = v >>> 15;
`endif
    if (r > 32767) return 16'h7FFF;
    if (r < -32768) return 16'h8000;
    return r[15:0];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One low-high-low pulse; keep=0 means the sample is expected to be lost
  task automatic pulse(input longint v, input bit keep);
    bus.fir_dout  = v[40:0];
    bus.fir_valid = 1'b1;
    if (keep) sb.push_back(model(v));
    tick;
    bus.fir_valid = 1'b0;
    bus.fir_dout  = 41'($urandom);
    tick;
  endtask

  task automatic wait_empty(input string tag);
    for (int i = 0; i < 60 && bus.out_valid; i++) tick;
    chk(tag, count, 0);
  endtask

  // Scoreboard: every accepted transfer must match the oldest expected sample
  always @(negedge clk) begin
    if (rstn === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      tests++;
      assert (sb.size() > 0) else begin
        fails++;
        $error("FAIL sb_extra observed=%0h expected=none", bus.out_data);
      end
      if (sb.size() > 0) begin
        exp_q = sb.pop_front();
        tests++;
        assert (bus.out_data === exp_q) else begin
          fails++;
          $error("FAIL sb_data observed=%0h expected=%0h", bus.out_data, exp_q);
        end
      end
    end
  end

  initial begin
    rstn          = 1'b0;
    clear         = 1'b0;
    bus.fir_valid = 1'b1;
    bus.fir_dout  = 41'd98304;
    bus.out_ready = 1'b0;
    tick;
    tick;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_count", count, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_sat_cnt", sat_cnt, 0);

    // valid already high at reset release must not be captured
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) tick;
    chk("held_at_release", count, 0);
    bus.fir_valid = 1'b0;
    tick;

    // basic result and two-cycle latency
    bus.out_ready = 1'b1;
    bus.fir_dout  = 41'd98304;
    bus.fir_valid = 1'b1;
    sb.push_back(model(98304));
    tick;
    bus.fir_valid = 1'b0;
    chk("lat_t1", bus.out_valid, 0);
    tick;
    chk("lat_t2", bus.out_valid, 1);
    chk("lat_data", bus.out_data, 16'h0003);
    tick;
    chk("t1_count", count, 0);
    chk("t1_sat", sat_cnt, 0);

    // rounding-sensitive value, then both saturation directions
    pulse(64'sd16384, 1'b1);
    pulse(64'sd4294967296, 1'b1);
    pulse(-64'sd4294967296, 1'b1);
    wait_empty("sat_drain");
    chk("sat_cnt2", sat_cnt, 2);

    // level held high with changing data gives one entry from the first cycle
    bus.out_ready = 1'b0;
    bus.fir_valid = 1'b1;
    bus.fir_dout  = 41'd5 << 15;
    sb.push_back(model(64'sd5 << 15));
    tick;
    for (int k = 6; k < 10; k++) begin
      bus.fir_dout = 41'(k) << 15;
      tick;
    end
    bus.fir_valid = 1'b0;
    tick;
    tick;
    tick;
    chk("held_count", count, 1);
    bus.out_ready = 1'b1;
    wait_empty("held_drain");

    // clear zeroes status and discards an edge in the same cycle
    bus.out_ready = 1'b0;
    bus.fir_dout  = 41'd7 << 15;
    bus.fir_valid = 1'b1;
    clear         = 1'b1;
    tick;
    clear         = 1'b0;
    bus.fir_valid = 1'b0;
    tick;
    tick;
    tick;
    chk("clr_count", count, 0);
    chk("clr_sat", sat_cnt, 0);
    chk("clr_overflow", overflow, 0);

    // fill to full
    for (int k = 1; k <= 8; k++) pulse(longint'(k) << 15, 1'b1);
    chk("full_count", count, 8);
    chk("full_ovf0", overflow, 0);

    // write while full with a pop in the same cycle is accepted
    bus.fir_dout  = 41'd9 << 15;
    bus.fir_valid = 1'b1;
    sb.push_back(model(64'sd9 << 15));
    tick;
    bus.fir_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick;
    bus.out_ready = 1'b0;
    chk("fullpop_count", count, 8);
    chk("fullpop_ovf", overflow, 0);

    // write while full without a pop is dropped
    pulse(64'sd10 << 15, 1'b0);
    chk("drop_count", count, 8);
    chk("drop_ovf", overflow, 1);
    bus.out_ready = 1'b1;
    wait_empty("drop_drain");
    chk("ovf_sticky", overflow, 1);

    // asynchronous reset mid-stream
    bus.out_ready = 1'b0;
    for (int k = 1; k <= 3; k++) pulse(longint'(k) << 15, 1'b1);
    chk("pre_rst_count", count, 3);
    rstn = 1'b0;
    #2;
    chk("arst_out_valid", bus.out_valid, 0);
    chk("arst_count", count, 0);
    chk("arst_ovf", overflow, 0);
    sb.delete();
    tick;
    rstn = 1'b1;
    tick;
    bus.out_ready = 1'b1;
    bus.fir_dout  = 41'd11 << 15;
    bus.fir_valid = 1'b1;
    sb.push_back(model(64'sd11 << 15));
    tick;
    bus.fir_valid = 1'b0;
    chk("post_lat_t1", bus.out_valid, 0);
    tick;
    chk("post_lat_t2", bus.out_valid, 1);
    tick;
    chk("post_count", count, 0);
    chk("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
